// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - requester, response and ALU bus bundle for alu_arbiter
interface alu_arbiter_if;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_opcode, req1_opcode;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        resp0_valid, resp1_valid;
  logic [31:0] resp0_result, resp1_result;
  logic        resp0_carry, resp0_zero, resp1_carry, resp1_zero;
  logic [31:0] alu_inOne, alu_inTwo;
  logic [3:0]  alu_opcode;
  logic [31:0] alu_result;
  logic        alu_carryBit, alu_zeroFlag;

  modport master (
    output req0_valid, req1_valid, req0_opcode, req1_opcode,
           req0_a, req0_b, req1_a, req1_b,
           alu_result, alu_carryBit, alu_zeroFlag,
    input  req0_ready, req1_ready, resp0_valid, resp1_valid,
           resp0_result, resp1_result, resp0_carry, resp0_zero, resp1_carry, resp1_zero,
           alu_inOne, alu_inTwo, alu_opcode
  );

  modport slave (
    input  req0_valid, req1_valid, req0_opcode, req1_opcode,
           req0_a, req0_b, req1_a, req1_b,
           alu_result, alu_carryBit, alu_zeroFlag,
    output req0_ready, req1_ready, resp0_valid, resp1_valid,
           resp0_result, resp1_result, resp0_carry, resp0_zero, resp1_carry, resp1_zero,
           alu_inOne, alu_inTwo, alu_opcode
  );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester arbiter sharing one registered-result ALU
// One operation in flight at a time: accept, wait one cycle for the ALU, capture.
module alu_arbiter #(
  parameter int FIXED_PRIO = 0
) (
  input  logic         clock,
  input  logic         reset,
  alu_arbiter_if.slave bus,
  output logic         busy
);
  typedef enum logic [1:0] {IDLE, EXEC, CAPT} state_t;

  localparam logic FIXED = (FIXED_PRIO != 0);

  state_t state;
  logic   lastGrant;
  logic   grantId;
  logic   pick0, pick1;
  logic   accept0, accept1;

  // On a tie requester 0 wins unless it was the one granted last.
  always_comb begin
    pick0 = bus.req0_valid & (~bus.req1_valid | FIXED | lastGrant);
    pick1 = bus.req1_valid & ~pick0;
  end

  assign accept0 = (state == IDLE) & ~reset & pick0;
  assign accept1 = (state == IDLE) & ~reset & pick1;
  assign bus.req0_ready = accept0;
  assign bus.req1_ready = accept1;

  always_ff @(posedge clock) begin
    if (reset) begin
      state            <= IDLE;
      busy             <= 1'b0;
      lastGrant        <= 1'b1;
      grantId          <= 1'b0;
      bus.alu_opcode   <= 4'b0000;
      bus.alu_inOne    <= '0;
      bus.alu_inTwo    <= '0;
      bus.resp0_valid  <= 1'b0;
      bus.resp1_valid  <= 1'b0;
      bus.resp0_result <= '0;
      bus.resp1_result <= '0;
      bus.resp0_carry  <= 1'b0;
      bus.resp0_zero   <= 1'b0;
      bus.resp1_carry  <= 1'b0;
      bus.resp1_zero   <= 1'b0;
    end else begin
      bus.resp0_valid <= 1'b0;
      bus.resp1_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (accept0 | accept1) begin
            state          <= EXEC;
            busy           <= 1'b1;
            grantId        <= accept1;
            lastGrant      <= accept1;
            bus.alu_opcode <= accept1 ? bus.req1_opcode : bus.req0_opcode;
            bus.alu_inOne  <= accept1 ? bus.req1_a : bus.req0_a;
            bus.alu_inTwo  <= accept1 ? bus.req1_b : bus.req0_b;
          end
        end
        EXEC: state <= CAPT;
        CAPT: begin
          // ALU operands are still held here, so the combinational zero flag is current.
          state <= IDLE;
          busy  <= 1'b0;
          if (grantId) begin
            bus.resp1_valid  <= 1'b1;
            bus.resp1_result <= bus.alu_result;
            bus.resp1_carry  <= bus.alu_carryBit;
            bus.resp1_zero   <= bus.alu_zeroFlag;
          end else begin
            bus.resp0_valid  <= 1'b1;
            bus.resp0_result <= bus.alu_result;
            bus.resp0_carry  <= bus.alu_carryBit;
            bus.resp0_zero   <= bus.alu_zeroFlag;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - self-checking bench for alu_arbiter (round-robin and fixed-priority instances)
module tb_alu_arbiter;
  logic clock = 1'b0;
  logic reset = 1'b1;
  logic busy0, busy1;

  alu_arbiter_if bus0();
  alu_arbiter_if bus1();

  alu_arbiter #(.FIXED_PRIO(0)) dutRr (.clock(clock), .reset(reset), .bus(bus0), .busy(busy0));
  alu_arbiter #(.FIXED_PRIO(1)) dutFx (.clock(clock), .reset(reset), .bus(bus1), .busy(busy1));

  always #5 clock = ~clock;

  // Stand-in ALU: {zeroFlag, carry, result}; zero flag means the operands are equal.
  function automatic logic [33:0] aluRef(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [32:0] w;
    logic [31:0] r;
    logic        c;
    r = '0;
    c = 1'b0;
    case (op)
      4'b0001: r = a & b;
      4'b0011: r = a | b;
      4'b0100: r = a ^ b;
      4'b0010: begin w = {1'b0, a} + {1'b0, b}; r = w[31:0]; c = w[32]; end
      4'b0110: begin w = {1'b0, a} - {1'b0, b}; r = w[31:0]; c = w[32]; end
      4'b0111: r = (a <= b) ? 32'd1 : 32'd0;
      default: ;
    endcase
    return {a == b, c, r};
  endfunction

  logic [33:0] aluOut0, aluOut1;
  assign aluOut0 = aluRef(bus0.alu_opcode, bus0.alu_inOne, bus0.alu_inTwo);
  assign aluOut1 = aluRef(bus1.alu_opcode, bus1.alu_inOne, bus1.alu_inTwo);
  assign bus0.alu_zeroFlag = aluOut0[33];
  assign bus1.alu_zeroFlag = aluOut1[33];
  always @(posedge clock) begin
    bus0.alu_result   <= aluOut0[31:0];
    bus0.alu_carryBit <= aluOut0[32];
    bus1.alu_result   <= aluOut1[31:0];
    bus1.alu_carryBit <= aluOut1[32];
  end

  int checks = 0;
  int errors = 0;

  // Requester side: index [dut][requester]
  bit          pend[2][2];
  logic [3:0]  pOp[2][2];
  logic [31:0] pA[2][2], pB[2][2];
  int          genPct[2][2];

  // Reference model
  int          busyLeft[2], respLeft[2], respId[2];
  bit          fire[2];
  int          lastG[2];
  logic [31:0] expRes[2][2];
  logic        expC[2][2], expZ[2][2];
  logic [3:0]  expOp[2];
  logic [31:0] expA[2], expB[2];
  int          grants0[$], grants1[$];

  task automatic clear_model(input int m);
    busyLeft[m] = 0; respLeft[m] = 0; respId[m] = 0; fire[m] = 1'b0; lastG[m] = 1;
    expOp[m] = 4'b0000; expA[m] = '0; expB[m] = '0;
    for (int r = 0; r < 2; r++) begin expRes[m][r] = '0; expC[m][r] = 1'b0; expZ[m][r] = 1'b0; end
  endtask

  task automatic drive();
    bus0.req0_valid = pend[0][0]; bus0.req0_opcode = pOp[0][0]; bus0.req0_a = pA[0][0]; bus0.req0_b = pB[0][0];
    bus0.req1_valid = pend[0][1]; bus0.req1_opcode = pOp[0][1]; bus0.req1_a = pA[0][1]; bus0.req1_b = pB[0][1];
    bus1.req0_valid = pend[1][0]; bus1.req0_opcode = pOp[1][0]; bus1.req0_a = pA[1][0]; bus1.req0_b = pB[1][0];
    bus1.req1_valid = pend[1][1]; bus1.req1_opcode = pOp[1][1]; bus1.req1_a = pA[1][1]; bus1.req1_b = pB[1][1];
  endtask

  // One clock: new requests, compare everything against the model, advance the model on the edge.
  task automatic step();
    int          win[2];
    logic        aRdy[2][2], aRv[2][2], aC[2][2], aZ[2][2], aBusy[2];
    logic [31:0] aRes[2][2], aIn1[2], aIn2[2];
    logic [3:0]  aOp[2];
    logic [33:0] ro;
    for (int m = 0; m < 2; m++)
      for (int r = 0; r < 2; r++)
        if (!pend[m][r] && genPct[m][r] > 0 && $urandom_range(99) < genPct[m][r]) begin
          pend[m][r] = 1'b1;
          pOp[m][r]  = 4'($urandom_range(15));
          pA[m][r]   = ($urandom_range(7) == 0) ? 32'hFFFF_FFFF : $urandom;
          pB[m][r]   = ($urandom_range(3) == 0) ? pA[m][r] : $urandom;
        end
    drive();
    #1;
    aRdy[0][0] = bus0.req0_ready; aRdy[0][1] = bus0.req1_ready; aRdy[1][0] = bus1.req0_ready; aRdy[1][1] = bus1.req1_ready;
    aRv[0][0] = bus0.resp0_valid; aRv[0][1] = bus0.resp1_valid; aRv[1][0] = bus1.resp0_valid; aRv[1][1] = bus1.resp1_valid;
    aRes[0][0] = bus0.resp0_result; aRes[0][1] = bus0.resp1_result; aRes[1][0] = bus1.resp0_result; aRes[1][1] = bus1.resp1_result;
    aC[0][0] = bus0.resp0_carry; aC[0][1] = bus0.resp1_carry; aC[1][0] = bus1.resp0_carry; aC[1][1] = bus1.resp1_carry;
    aZ[0][0] = bus0.resp0_zero; aZ[0][1] = bus0.resp1_zero; aZ[1][0] = bus1.resp0_zero; aZ[1][1] = bus1.resp1_zero;
    aBusy[0] = busy0; aBusy[1] = busy1;
    aOp[0] = bus0.alu_opcode; aOp[1] = bus1.alu_opcode;
    aIn1[0] = bus0.alu_inOne; aIn1[1] = bus1.alu_inOne;
    aIn2[0] = bus0.alu_inTwo; aIn2[1] = bus1.alu_inTwo;
    for (int m = 0; m < 2; m++) begin
      win[m] = -1;
      if (busyLeft[m] == 0 && !reset) begin
        if (pend[m][0] && pend[m][1]) win[m] = (m == 1) ? 0 : 1 - lastG[m];
        else if (pend[m][0])          win[m] = 0;
        else if (pend[m][1])          win[m] = 1;
      end
      checks++;
      if (aBusy[m] !== (busyLeft[m] > 0)) begin
        errors++; $display("FAIL busy dut%0d t=%0t: got %b expected %b", m, $time, aBusy[m], busyLeft[m] > 0);
      end
      checks += 3;
      if (aOp[m] !== expOp[m] || aIn1[m] !== expA[m] || aIn2[m] !== expB[m]) begin
        errors++; $display("FAIL alu_operands dut%0d t=%0t: got %h/%h/%h expected %h/%h/%h",
                           m, $time, aOp[m], aIn1[m], aIn2[m], expOp[m], expA[m], expB[m]);
      end
      for (int r = 0; r < 2; r++) begin
        checks++;
        if (aRdy[m][r] !== (win[m] == r)) begin
          errors++; $display("FAIL ready dut%0d req%0d t=%0t: got %b expected %b", m, r, $time, aRdy[m][r], win[m] == r);
        end
        checks++;
        if (aRv[m][r] !== (fire[m] && respId[m] == r)) begin
          errors++; $display("FAIL resp_valid dut%0d req%0d t=%0t: got %b expected %b", m, r, $time, aRv[m][r], fire[m] && respId[m] == r);
        end
        checks += 3;
        if (aRes[m][r] !== expRes[m][r] || aC[m][r] !== expC[m][r] || aZ[m][r] !== expZ[m][r]) begin
          errors++; $display("FAIL resp_data dut%0d req%0d t=%0t: got %h c%b z%b expected %h c%b z%b",
                             m, r, $time, aRes[m][r], aC[m][r], aZ[m][r], expRes[m][r], expC[m][r], expZ[m][r]);
        end
      end
    end
    @(posedge clock);
    for (int m = 0; m < 2; m++) begin
      fire[m] = 1'b0;
      if (reset) clear_model(m);
      else begin
        if (respLeft[m] > 0) begin
          respLeft[m]--;
          if (respLeft[m] == 0) begin
            ro = aluRef(expOp[m], expA[m], expB[m]);
            expRes[m][respId[m]] = ro[31:0];
            expC[m][respId[m]]   = ro[32];
            expZ[m][respId[m]]   = ro[33];
            fire[m] = 1'b1;
          end
        end
        if (busyLeft[m] > 0) busyLeft[m]--;
        if (win[m] >= 0) begin
          busyLeft[m] = 2; respLeft[m] = 2; respId[m] = win[m]; lastG[m] = win[m];
          expOp[m] = pOp[m][win[m]]; expA[m] = pA[m][win[m]]; expB[m] = pB[m][win[m]];
          pend[m][win[m]] = 1'b0;
          if (m == 0) grants0.push_back(win[m]); else grants1.push_back(win[m]);
        end
      end
    end
    @(negedge clock);
  endtask

  // Issue one op and return at the negedge two cycles after its accept edge.
  task automatic run_op(input int m, input int r, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, output int tries);
    tries = 0;
    pend[m][r] = 1'b1; pOp[m][r] = op; pA[m][r] = a; pB[m][r] = b;
    while (pend[m][r] && tries < 10) begin step(); tries++; end
    if (pend[m][r]) begin
      errors++; $display("FAIL accept_timeout dut%0d req%0d: no ready within %0d cycles", m, r, tries);
      pend[m][r] = 1'b0;
    end
    step(); step();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive();
    repeat (3) @(negedge clock);
    for (int m = 0; m < 2; m++) clear_model(m);
    checks += 8;
    if (busy0 !== 1'b0 || busy1 !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b %b expected 0 0", busy0, busy1); end
    if (bus0.alu_opcode !== 4'b0000) begin errors++; $display("FAIL reset_alu_opcode: got %h expected 0", bus0.alu_opcode); end
    if (bus0.alu_inOne !== 32'd0 || bus0.alu_inTwo !== 32'd0) begin errors++; $display("FAIL reset_alu_in: got %h %h expected 0 0", bus0.alu_inOne, bus0.alu_inTwo); end
    if (bus0.resp0_valid !== 1'b0 || bus0.resp1_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b %b expected 0 0", bus0.resp0_valid, bus0.resp1_valid); end
    if (bus0.resp0_result !== 32'd0 || bus0.resp1_result !== 32'd0) begin errors++; $display("FAIL reset_resp_result: got %h %h expected 0 0", bus0.resp0_result, bus0.resp1_result); end
    if (bus0.resp0_carry !== 1'b0 || bus0.resp1_zero !== 1'b0) begin errors++; $display("FAIL reset_resp_flags: got %b %b expected 0 0", bus0.resp0_carry, bus0.resp1_zero); end
    pend[0][0] = 1'b1; pend[0][1] = 1'b1; drive(); #1;
    if (bus0.req0_ready !== 1'b0 || bus0.req1_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b %b expected 0 0", bus0.req0_ready, bus0.req1_ready); end
    pend[0][0] = 1'b0; pend[0][1] = 1'b0;
    @(negedge clock);
    if (bus1.alu_inOne !== 32'd0) begin errors++; $display("FAIL reset_alu_in_fixed: got %h expected 0", bus1.alu_inOne); end
    step();
    reset = 1'b0;
  endtask

  task automatic test_single_op();
    int tries;
    run_op(0, 0, 4'b0010, 32'd5, 32'd7, tries);
    checks += 6;
    if (tries !== 1) begin errors++; $display("FAIL single_first_accept: got %0d cycles expected 1", tries); end
    if (bus0.resp0_valid !== 1'b1) begin errors++; $display("FAIL single_resp_valid: got %b expected 1", bus0.resp0_valid); end
    if (bus0.resp0_result !== 32'd12) begin errors++; $display("FAIL single_result: got %0d expected 12", bus0.resp0_result); end
    if (bus0.resp0_carry !== 1'b0 || bus0.resp0_zero !== 1'b0) begin errors++; $display("FAIL single_flags: got c%b z%b expected c0 z0", bus0.resp0_carry, bus0.resp0_zero); end
    if (bus0.resp1_valid !== 1'b0) begin errors++; $display("FAIL single_resp1_quiet: got %b expected 0", bus0.resp1_valid); end
    step();
    if (bus0.resp0_valid !== 1'b0 || bus0.resp0_result !== 32'd12) begin
      errors++; $display("FAIL single_pulse_hold: got v%b %0d expected v0 12", bus0.resp0_valid, bus0.resp0_result);
    end
  endtask

  task automatic test_carry_zero();
    int tries;
    run_op(0, 1, 4'b0010, 32'hFFFF_FFFF, 32'd1, tries);
    checks += 2;
    if (bus0.resp1_valid !== 1'b1 || bus0.resp1_result !== 32'd0) begin errors++; $display("FAIL carry_result: got v%b %h expected v1 0", bus0.resp1_valid, bus0.resp1_result); end
    if (bus0.resp1_carry !== 1'b1) begin errors++; $display("FAIL carry_bit: got %b expected 1", bus0.resp1_carry); end
    run_op(0, 1, 4'b0111, 32'd0, 32'd0, tries);
    checks += 2;
    if (bus0.resp1_result !== 32'd1) begin errors++; $display("FAIL compare_result: got %h expected 1", bus0.resp1_result); end
    if (bus0.resp1_zero !== 1'b1) begin errors++; $display("FAIL compare_zero: got %b expected 1", bus0.resp1_zero); end
  endtask

  task automatic test_undefined_opcode();
    int tries;
    step();
    run_op(0, 0, 4'b0000, 32'd3, 32'd4, tries);
    checks += 3;
    if (tries !== 1) begin errors++; $display("FAIL undef_accept: got %0d cycles expected 1", tries); end
    if (bus0.resp0_valid !== 1'b1 || bus0.resp0_result !== 32'd0) begin errors++; $display("FAIL undef_result: got v%b %h expected v1 0", bus0.resp0_valid, bus0.resp0_result); end
    if (bus0.resp0_carry !== 1'b0) begin errors++; $display("FAIL undef_carry: got %b expected 0", bus0.resp0_carry); end
  endtask

  task automatic test_round_robin();
    reset = 1'b1; step(); reset = 1'b0;
    grants0.delete();
    genPct[0][0] = 100; genPct[0][1] = 100;
    repeat (12) step();
    genPct[0][0] = 0; genPct[0][1] = 0;
    checks++;
    if (grants0.size() != 4) begin errors++; $display("FAIL rr_grant_count: got %0d expected 4", grants0.size()); end
    for (int i = 0; i < grants0.size() && i < 4; i++) begin
      checks++;
      if (grants0[i] != i % 2) begin errors++; $display("FAIL rr_grant_order idx%0d: got %0d expected %0d", i, grants0[i], i % 2); end
    end
    repeat (8) step();
  endtask

  task automatic test_fixed_prio();
    reset = 1'b1; step(); reset = 1'b0;
    grants1.delete();
    genPct[1][0] = 100; genPct[1][1] = 100;
    repeat (10) step();
    genPct[1][0] = 0; genPct[1][1] = 0;
    checks++;
    if (grants1.size() != 4) begin errors++; $display("FAIL fixed_grant_count: got %0d expected 4", grants1.size()); end
    for (int i = 0; i < grants1.size(); i++) begin
      checks++;
      if (grants1[i] != 0) begin errors++; $display("FAIL fixed_grant idx%0d: got %0d expected 0", i, grants1[i]); end
    end
    pend[1][0] = 1'b0;
    repeat (6) step();
  endtask

  task automatic test_reset_mid_op();
    int tries;
    tries = 0;
    pend[0][0] = 1'b1; pOp[0][0] = 4'b0010; pA[0][0] = 32'd100; pB[0][0] = 32'd23;
    while (pend[0][0] && tries < 10) begin step(); tries++; end
    checks++;
    if (busy0 !== 1'b1) begin errors++; $display("FAIL midop_in_exec: got busy %b expected 1", busy0); end
    reset = 1'b1; step(); reset = 1'b0;
    checks += 3;
    if (busy0 !== 1'b0 || bus0.resp0_valid !== 1'b0) begin errors++; $display("FAIL midop_discard: got busy%b v%b expected 0 0", busy0, bus0.resp0_valid); end
    if (bus0.alu_opcode !== 4'b0000 || bus0.alu_inOne !== 32'd0) begin errors++; $display("FAIL midop_alu_reset: got %h %h expected 0 0", bus0.alu_opcode, bus0.alu_inOne); end
    if (bus0.resp0_result !== 32'd0) begin errors++; $display("FAIL midop_resp_reset: got %h expected 0", bus0.resp0_result); end
    run_op(0, 0, 4'b0100, 32'hF0F0_0000, 32'h0FF0_0001, tries);
    checks += 2;
    if (tries !== 1) begin errors++; $display("FAIL midop_first_accept: got %0d cycles expected 1", tries); end
    if (bus0.resp0_valid !== 1'b1 || bus0.resp0_result !== 32'hFF00_0001) begin
      errors++; $display("FAIL midop_new_op: got v%b %h expected v1 ff000001", bus0.resp0_valid, bus0.resp0_result);
    end
  endtask

  task automatic test_random();
    for (int m = 0; m < 2; m++) for (int r = 0; r < 2; r++) genPct[m][r] = 40;
    repeat (1500) begin
      reset = ($urandom_range(199) == 0);
      step();
    end
    reset = 1'b0;
    for (int m = 0; m < 2; m++) for (int r = 0; r < 2; r++) genPct[m][r] = 0;
    repeat (20) step();
  endtask

  initial begin
    for (int m = 0; m < 2; m++)
      for (int r = 0; r < 2; r++) begin
        pend[m][r] = 1'b0; pOp[m][r] = '0; pA[m][r] = '0; pB[m][r] = '0; genPct[m][r] = 0;
      end
    test_reset();
    test_single_op();
    test_carry_zero();
    test_undefined_opcode();
    test_round_robin();
    test_fixed_prio();
    test_reset_mid_op();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: FIXED_PRIO, default 0, meaning 0 = round-robin between requesters, 1 = requester 0 always wins.
REQ-002 Port: clock  input  1  sole clock; all state updates on posedge clock.
REQ-003 Port: reset  input  1  synchronous, active-high reset.
REQ-004 Ports: req0_valid, req1_valid  input  1 each  requester has an operation pending.
REQ-005 Ports: req0_ready, req1_ready  output  1 each  arbiter accepts that requester's operation this cycle.
REQ-006 Ports: req0_opcode, req1_opcode  input  4 each  ALU control code, using the ALU's opcode encoding.
REQ-007 Ports: req0_a, req0_b, req1_a, req1_b  input  32 each  operand 1 / operand 2.
REQ-008 Ports: resp0_valid, resp1_valid  output  1 each  one-cycle pulse; the response belongs to that requester.
REQ-009 Ports: resp0_result, resp1_result  output  32 each  captured ALU result.
REQ-010 Ports: resp0_carry, resp0_zero, resp1_carry, resp1_zero  output  1 each  captured carry bit / zero flag.
REQ-011 Ports: alu_inOne, alu_inTwo  output  32 each  registered operands driven to the ALU.
REQ-012 Port: alu_opcode  output  4  registered opcode driven to the ALU.
REQ-013 Ports: alu_result (input, 32), alu_carryBit (input, 1), alu_zeroFlag (input, 1)  ALU outputs.
REQ-014 Port: busy  output  1  high whenever the state is not IDLE.

Function
REQ-015 The FSM SHALL have three states (IDLE, EXEC, CAPT) and SHALL follow IDLE->EXEC on an accepted request, EXEC->CAPT unconditionally, and CAPT->IDLE unconditionally.
REQ-016 reqN_ready SHALL be asserted only in IDLE, for at most one requester, and only when that requester's reqN_valid is high; it is combinational from valid.
REQ-017 Grant selection:
- Only one valid: grant it.
- Both valid, FIXED_PRIO=1: requester 0 wins.
- Both valid, FIXED_PRIO=0: the requester not granted last wins.
REQ-018 The last-grant register SHALL update only on an accepted handshake (valid&ready).
REQ-019 On the accept edge, the granted opcode/a/b SHALL be loaded into alu_opcode/alu_inOne/alu_inTwo and the grant id SHALL be stored.
REQ-020 alu_* outputs SHALL hold their values unchanged through EXEC and CAPT, so the combinational zero flag stays valid.
REQ-021 Edge timing for an operation accepted at edge N:
- Edge N+1: ALU registers its result.
- Edge N+2: arbiter captures alu_result, alu_carryBit and alu_zeroFlag into the stored id's resp registers and asserts that respN_valid for exactly one cycle (N+2 to N+3).
REQ-022 Accept-to-response latency SHALL be 2 cycles; the next accept SHALL be possible no earlier than edge N+3 (throughput one op per 3 cycles).
REQ-023 respN_result/carry/zero SHALL hold their last captured values until the next response to the same requester.
REQ-024 The opcode SHALL be forwarded unmodified, including undefined codes (the ALU returns result 0 for these).
REQ-025 Requesters SHALL hold valid and payload stable until ready; a deasserted valid with no ready means no operation.
REQ-026 resp0_valid and resp1_valid SHALL never be high in the same cycle.

Reset
REQ-027 While reset is high at a posedge, the block SHALL enter IDLE and drive: busy=0, both ready=0, both resp_valid=0, alu_opcode=4'b0000, alu_inOne=0, alu_inTwo=0, all resp result/carry/zero=0, last grant=1 (requester 0 wins the first round-robin tie).
REQ-028 Reset asserted in EXEC or CAPT SHALL discard the in-flight operation; no response pulse is produced for it.
REQ-029 The first accept after reset SHALL be possible on the first edge with reset low.

Verification
REQ-030 Single op: req0 opcode 0010, a=5, b=7 accepted at edge N -> resp0_valid at N+2 only, resp0_result=12, carry=0, zero=0; resp1_valid stays 0.
REQ-031 Carry: req1 opcode 0010, a=FFFFFFFF, b=1 -> resp1_result=0, resp1_carry=1; req1 opcode 0111, b=0 -> resp1_result=1, resp1_zero=1.
REQ-032 Round-robin: both valid continuously, FIXED_PRIO=0 -> grants 0,1,0,1, each response 3 cycles apart, each response matches its own operands.
REQ-033 Fixed priority: FIXED_PRIO=1, both valid for 3 ops -> all grants to requester 0; req1 waits with req1_ready=0.
REQ-034 Reset mid-op: reset high in EXEC -> no resp pulse; outputs at reset values; a new req0 accept on the first cycle after reset completes normally.
REQ-035 Undefined opcode 0000, a=3, b=4 -> resp result=0, carry=0, latency still 2.
